// File: rtl/mag_comp_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   DIG_W            : width of one operand digit (bits)
//   N_DIGITS_DEFAULT : default number of digits per operand word
//   state_e          : controller state encoding
package mag_comp_pkg;

    localparam int unsigned DIG_W            = 2;
    localparam int unsigned N_DIGITS_DEFAULT = 4;

    typedef enum logic [1:0] {
        StIdle,
        StCmp,
        StDone
    } state_e;

endpackage

// File: rtl/mag_slice_2bit.sv
// Combinational compare of one 2-bit digit pair.
// Ports:
//   a, b : digit of operand A / operand B
//   L    : a < b
//   G    : a > b
//   E    : a == b
module mag_slice_2bit
    import mag_comp_pkg::*;
(
    input  logic [DIG_W-1:0] a,
    input  logic [DIG_W-1:0] b,
    output logic             L,
    output logic             G,
    output logic             E
);

    assign L = (a < b);
    assign G = (a > b);
    assign E = (a == b);

endmodule

// File: rtl/mag_comp_serial.sv
// Serial magnitude comparator: two operand words arrive one 2-bit digit pair
// per accepted cycle, MSB digit first. The first digit that differs decides
// the result; L/G/E are presented with out_valid until the consumer takes them.
// Build option: define MAG_COMP_SIGNED_EN to compare two's complement operands
// (sign bit of the start digit inverted before the slice compare); otherwise
// operands are unsigned.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : digit pair handshake
//   start               : presented digit is the MSB digit of a new word
//   a, b                : current digit of operand A / operand B
//   out_valid/out_ready : result handshake
//   L, G, E             : A<B, A>B, A==B (one-hot while out_valid)
module mag_comp_serial
    import mag_comp_pkg::*;
#(
    parameter int unsigned N_DIGITS = N_DIGITS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             start,
    input  logic [DIG_W-1:0] a,
    input  logic [DIG_W-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             L,
    output logic             G,
    output logic             E
);

    localparam int unsigned     CntW    = $clog2(N_DIGITS + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(N_DIGITS);

    state_e          state_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            dec_q, dec_d;
    logic            lt_q, lt_d;
    logic            gt_q, gt_d;

    logic [DIG_W-1:0] a_eff, b_eff;
    logic             sl_l, sl_g, sl_e;
    logic             accept;
    logic             take;

    // DONE only releases the input side when the result is being consumed.
    assign in_ready = (state_q == StDone) ? out_ready : 1'b1;
    assign accept   = in_valid & in_ready;
    // Digits count only when they open a word or continue one in progress.
    assign take     = accept & (start | (state_q == StCmp));

    always_comb begin
        a_eff = a;
        b_eff = b;
`ifdef MAG_COMP_SIGNED_EN
        // Flipping the sign bit maps two's complement order onto unsigned order.
        if (start) begin
            a_eff[DIG_W-1] = ~a[DIG_W-1];
            b_eff[DIG_W-1] = ~b[DIG_W-1];
        end
`endif
    end

    mag_slice_2bit u_slice (
        .a (a_eff),
        .b (b_eff),
        .L (sl_l),
        .G (sl_g),
        .E (sl_e)
    );

    always_comb begin
        cnt_d = start ? CntW'(1) : cnt_q + CntW'(1);
        dec_d = dec_q;
        lt_d  = lt_q;
        gt_d  = gt_q;
        // A start digit forgets any earlier decision; otherwise the first
        // unequal digit wins and later digits are ignored.
        if (start || !dec_q) begin
            dec_d = ~sl_e;
            lt_d  = sl_l;
            gt_d  = sl_g;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            dec_q     <= 1'b0;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
            out_valid <= 1'b0;
            L         <= 1'b0;
            G         <= 1'b0;
            E         <= 1'b0;
        end else if (take) begin
            cnt_q <= cnt_d;
            dec_q <= dec_d;
            lt_q  <= lt_d;
            gt_q  <= gt_d;
            if (cnt_d == CntLast) begin
                state_q   <= StDone;
                out_valid <= 1'b1;
                L         <= lt_d;
                G         <= gt_d;
                E         <= ~dec_d;
            end else begin
                state_q   <= StCmp;
                out_valid <= 1'b0;
                L         <= 1'b0;
                G         <= 1'b0;
                E         <= 1'b0;
            end
        end else if ((state_q == StDone) && out_ready) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            dec_q     <= 1'b0;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
            out_valid <= 1'b0;
            L         <= 1'b0;
            G         <= 1'b0;
            E         <= 1'b0;
        end
    end

endmodule

// File: doc/mag_comp_serial.md
MAG_COMP_SERIAL -- requirements
Module: mag_comp_serial

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, giving the number of 2-bit digits per operand word (word width 2*N_DIGITS); legal range 1..16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: a digit pair is presented.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a digit pair this cycle.
REQ-006 SHALL have port start, input, 1 bit: the presented digit pair is the MSB digit of a new word.
REQ-007 SHALL have port a, input, 2 bits: the current digit of operand A, sent MSB digit first.
REQ-008 SHALL have port b, input, 2 bits: the current digit of operand B, sent MSB digit first.
REQ-009 SHALL have port out_valid, output, 1 bit: the word result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have ports L, G, E, each output, 1 bit: A<B, A>B, A==B for the completed word; exactly one is high while out_valid=1.

Function
REQ-012 SHALL count a digit pair as accepted on any cycle with in_valid=1 and in_ready=1.
REQ-013 SHALL implement FSM states IDLE, CMP, DONE.
REQ-014 SHALL drive in_ready=1 in IDLE and CMP, and in_ready=out_ready in DONE.
REQ-015 SHALL, in IDLE, discard an accepted digit with start=0.
REQ-016 SHALL, on an accepted digit with start=1 in any state, clear the decided flag, set the digit count to 1, and evaluate that digit.
REQ-017 SHALL evaluate each accepted digit with a 2-bit slice compare; while undecided, a slice result of L or G latches that result and sets decided; once decided, later digits of the word do not change the result.
REQ-018 SHALL enter DONE on the cycle after the N_DIGITS-th accepted digit, with out_valid=1 and the latched L/G, or E=1 if never decided; for N_DIGITS=1 this is the cycle after the start digit.
REQ-019 SHALL hold out_valid, L, G and E stable in DONE until out_ready=1.
REQ-020 SHALL, in DONE with out_ready=1, leave DONE: go to CMP if a start digit is accepted that cycle, otherwise to IDLE.
REQ-021 SHALL, on start=1 in CMP, abandon the partial word without emitting a result and restart with the new digit.
REQ-022 SHALL drive out_valid=0 and L=G=E=0 outside DONE.

Reset
REQ-023 SHALL, with rst=1, go to IDLE with out_valid=0, L=G=E=0, digit count 0 and decided=0; in_ready=1 on the cycle after reset.
REQ-024 SHALL, on reset during CMP or DONE, discard the partial word or pending result and produce no out_valid for it.

Configuration
REQ-025 SHALL support macro MAG_COMP_SIGNED_EN: when defined, operands are two's complement, implemented by inverting bit 1 of both a and b on the start digit before the slice compare; when undefined, operands are unsigned and no inversion is applied.

Structure
REQ-026 SHALL take the FSM state enum, DIG_W=2 and the N_DIGITS default from shared package mag_comp_pkg.
REQ-027 SHALL instantiate one combinational sub-module, mag_slice_2bit (a, b -> L, G, E), for the per-digit compare.

Verification (N_DIGITS=4; 8-bit words, MSB digit first)
REQ-028 SHALL cover A=0xA5, B=0xA5 -> out_valid the cycle after the 4th digit, E=1, L=G=0.
REQ-029 SHALL cover A=0x5A, B=0x5B -> L=1, decided on the last digit.
REQ-030 SHALL cover A=0xC0, B=0x3F -> G=1, decided on the 1st digit; later digits favouring B leave G=1.
REQ-031 SHALL cover 2 digits of A=0xFF/B=0x00, then start with A=0x01, B=0x00 -> exactly one result, G=1.
REQ-032 SHALL cover out_ready=0 for 3 cycles in DONE -> outputs held and in_ready=0; then out_ready=1 with a start digit that same cycle -> digit accepted and state is CMP next cycle.
REQ-033 SHALL cover A=0x80, B=0x01 -> L=1 with MAG_COMP_SIGNED_EN defined, and G=1 without it; and reset asserted mid-word -> no out_valid.
